uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's UART transmitter.
- Samples an asynchronous serial line with a configurable clocks-per-bit ratio and validates the start bit.
- Outputs each received byte with a one-cycle valid pulse and flags framing errors.
- Intended to sit behind a TinyTapeout io_in pin and feed a byte consumer or message matcher.

Parameters:
CLKS_PER_BIT, 4, clock cycles per UART bit; even, >=2. HALF = CLKS_PER_BIT/2.
DATA_BITS, 8, data bits per frame, LSB first. Fixed at 8; the parameter is documentation only.

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line; idles high
data  output  8  last good received byte; holds until the next good frame
valid  output  1  one-cycle pulse when data is updated
frame_err  output  1  one-cycle pulse when the stop bit samples low
parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 when the option is out
busy  output  1  high in every state except IDLE

Behaviour:
- Input synchronizer: 2 flops, rx -> rx_s, reset value 1. All FSM decisions use rx_s only.
- Counters: cnt is $clog2(CLKS_PER_BIT) bits wide; bit_idx is 3 bits; shift register is 8 bits.
- Reset values: data=0x00, valid=0, frame_err=0, parity_err=0, busy=0, state=IDLE, cnt=0, bit_idx=0, both sync flops=1.
- IDLE: when rx_s==0 -> START, cnt<=0.
- START: cnt increments each cycle. At the edge where cnt==HALF-1:
  - rx_s==0 -> DATA, cnt<=0, bit_idx<=0.
  - rx_s==1 -> IDLE. This is glitch rejection: no pulse of any kind.
- DATA: at the edge where cnt==CLKS_PER_BIT-1:
  - shift rx_s into bit position bit_idx (LSB first); cnt<=0.
  - if bit_idx==7 -> STOP (or PARITY when the option is in); otherwise bit_idx++.
  - in all other cycles, cnt++.
- STOP: at the edge where cnt==CLKS_PER_BIT-1, sample rx_s:
  - 1 -> data<=shift, valid<=1 for one cycle, -> IDLE. The FSM returns half a bit early so it resyncs on the next start edge.
  - 0 -> frame_err<=1 for one cycle, data unchanged, -> BREAK.
- BREAK: wait until rx_s==1, then -> IDLE. A line held low therefore never retriggers; one frame_err per break.
- Latency: counting edge 0 as the first edge at which the rx input is sampled low, valid is high in the cycle after edge 2+HALF+9*CLKS_PER_BIT (edge 40 for CLKS_PER_BIT=4). Each data sample falls mid-bit relative to rx.
- Back-to-back frames: a start bit beginning right after the stop bit is received with no gap.
- Reset asserted mid-frame: on the next edge all state returns to reset values; a partial byte is discarded and no pulse is issued.
- valid, frame_err and parity_err are mutually exclusive in any cycle.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: an even-parity bit follows D7.
  - PARITY state samples it at cnt==CLKS_PER_BIT-1 and then -> STOP.
  - In STOP with a good stop bit, if XOR(data bits, parity bit) != 0: parity_err pulses, valid stays 0 and data is unchanged.
  - Latency grows by CLKS_PER_BIT cycles (edge 44 for CLKS_PER_BIT=4).
- Undefined:
  - PARITY state is absent and parity_err is constant 0.

Decomposition:
- Package uart_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - constants: START_BIT=0, STOP_BIT=1, IDLE_BIT=1, DATA_BITS=8.
  - shared with the transmitter.
- Sub-module: sync_2ff, a 2-flop synchronizer with parameterised reset value. The FSM, counters and shift register stay in uart_rx.

Test Plan:
1. CLKS_PER_BIT=4; send 'M' (0x4D), 8N1 -> data=0x4D, valid high for exactly one cycle after edge 40, busy low afterwards, frame_err=0.
2. Back-to-back "MM0\n" with no idle gap -> four valid pulses 40 cycles apart, with data 0x4D, 0x4D, 0x30, 0x0A.
3. rx low for 1 cycle only -> FSM returns to IDLE, no valid and no frame_err; a following 0x41 frame is received correctly.
4. Send 0x55 with stop bit forced 0, then rx held low 100 cycles, then high -> exactly one frame_err pulse, data keeps the previous value, busy stays high until rx returns high, no extra pulses.
5. Assert reset for 1 cycle mid-frame (after bit 3 of 0x48) -> all outputs return to reset values next edge and no valid pulse; the next full frame 0x21 is received correctly.
6. With UART_RX_PARITY_EN: 0x61 with correct parity 1 -> valid, data=0x61. 0x61 with parity 0 -> parity_err pulse only, data unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with start-bit validation and framing-error detection.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  logic                 w_rx_s;
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic                 r_par;
  logic                 r_parity_err;
`endif

  sync_2ff #(.RESET_VAL(IDLE_BIT)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_rx_s == START_BIT) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          // Re-check the line mid start bit; a short low glitch drops back silently.
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            if (w_rx_s == START_BIT) begin
              r_state   <= DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_shift[r_bit_idx] <= w_rx_s;
            r_cnt              <= '0;
            if (r_bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (r_cnt == CNT_LAST) begin
            r_par   <= w_rx_s;
            r_cnt   <= '0;
            r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          // Leave at mid stop bit so the next start edge is caught with no gap.
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (w_rx_s == STOP_BIT) begin
              r_state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (^{r_shift, r_par}) begin
                r_parity_err <= 1'b1;
              end else begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end
`else
              r_data  <= r_shift;
              r_valid <= 1'b1;
`endif
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (w_rx_s == IDLE_BIT) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule
